bp_me_stream_arb_out: RTL and testbench

- Round-robin arbiter that shares one outbound BedRock Stream link among num_req_p stream producers, typically the outputs of several stream pump-out instances.
- Each message (header plus 1..N data beats, terminated by last) is granted atomically. The grant is locked from the first accepted beat through the last accepted beat, so beats from different messages never interleave.
- Sits between per-engine pumps and a shared network or memory-side port in the ME.

---
 rtl/bp_me_stream_arb_out_pkg.sv | 9 +
 rtl/bp_me_stream_arb_out_if.sv | 32 +++
 rtl/bp_me_stream_arb_out_rr_sel.sv | 28 ++
 rtl/bp_me_stream_arb_out.sv | 105 ++++++++++
 tb/tb_bp_me_stream_arb_out.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_stream_arb_out_pkg.sv
// Shared types for the outbound BedRock stream arbiter.
package bp_me_stream_arb_out_pkg;

    typedef enum logic {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } bp_me_stream_arb_state_e;

endpackage

// File: rtl/bp_me_stream_arb_out_if.sv
// Request-side and link-side stream signals of the arbiter.
// master is the arbiter's view; slave is the requesters/downstream view.
interface bp_me_stream_arb_out_if
    import bp_me_stream_arb_out_pkg::*;
#(
    parameter int num_req_p           = 2,
    parameter int header_width_p      = 128,
    parameter int stream_data_width_p = 64
);

    logic [num_req_p*header_width_p-1:0]      req_header_i;
    logic [num_req_p*stream_data_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]                     req_v_i;
    logic [num_req_p-1:0]                     req_last_i;
    logic [num_req_p-1:0]                     req_ready_and_o;
    logic [header_width_p-1:0]                msg_header_o;
    logic [stream_data_width_p-1:0]           msg_data_o;
    logic                                     msg_v_o;
    logic                                     msg_last_o;
    logic                                     msg_ready_and_i;

    modport master (
        input  req_header_i, req_data_i, req_v_i, req_last_i, msg_ready_and_i,
        output req_ready_and_o, msg_header_o, msg_data_o, msg_v_o, msg_last_o
    );

    modport slave (
        output req_header_i, req_data_i, req_v_i, req_last_i, msg_ready_and_i,
        input  req_ready_and_o, msg_header_o, msg_data_o, msg_v_o, msg_last_o
    );

endinterface

// File: rtl/bp_me_stream_arb_out_rr_sel.sv
// Rotating priority encoder: first valid index at or above ptr_i, wrapping.
module bp_me_stream_rr_sel #(
    parameter  int num_req_p = 2,
    localparam int lg_req_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] v_i,
    input  logic [lg_req_lp-1:0] ptr_i,
    output logic [lg_req_lp-1:0] sel_o,
    output logic                 any_v_o
);

    logic [lg_req_lp:0] idx;

    // Scan from the farthest offset down so the nearest valid wins last.
    always_comb begin
        sel_o = '0;
        idx   = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_i} + (lg_req_lp + 1)'(k);
            if (idx >= (lg_req_lp + 1)'(num_req_p))
                idx = idx - (lg_req_lp + 1)'(num_req_p);
            if (v_i[idx[lg_req_lp-1:0]])
                sel_o = idx[lg_req_lp-1:0];
        end
        any_v_o = |v_i;
    end

endmodule

// File: rtl/bp_me_stream_arb_out.sv
// Round-robin arbiter sharing one outbound stream link; each message is
// granted atomically from its first accepted beat through its last.
module bp_me_stream_arb_out
    import bp_me_stream_arb_out_pkg::*;
#(
    parameter  int num_req_p           = 2,
    parameter  int header_width_p      = 128,
    parameter  int stream_data_width_p = 64,
    parameter  int hold_on_valid_p     = 0,
    localparam int lg_req_lp           = $clog2(num_req_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_me_stream_arb_out_if.master      link,
    output logic [lg_req_lp-1:0]        grant_o,
    output logic                        lock_o
);

    bp_me_stream_arb_state_e state_q;
    logic [lg_req_lp-1:0]    grant_q;
    logic [lg_req_lp-1:0]    ptr_q;
    logic [lg_req_lp-1:0]    ptr_d;
    logic [lg_req_lp-1:0]    sel;
    logic                    any_v;
    logic [lg_req_lp-1:0]    route_idx;
    logic [num_req_p-1:0]    route_oh;
    logic                    sel_v;
    logic                    xfer;
    logic                    msg_done;

    bp_me_stream_rr_sel #(.num_req_p(num_req_p)) rr_sel (
        .v_i     (link.req_v_i),
        .ptr_i   (ptr_q),
        .sel_o   (sel),
        .any_v_o (any_v)
    );

    always_comb begin
        route_idx = (state_q == e_locked) ? grant_q : sel;
        route_oh  = '0;
        route_oh[route_idx] = 1'b1;

        link.msg_header_o = '0;
        link.msg_data_o   = '0;
        link.msg_last_o   = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            link.msg_header_o |= link.req_header_i[i*header_width_p +: header_width_p]
                                 & {header_width_p{route_oh[i]}};
            link.msg_data_o   |= link.req_data_i[i*stream_data_width_p +: stream_data_width_p]
                                 & {stream_data_width_p{route_oh[i]}};
            link.msg_last_o   |= link.req_last_i[i] & route_oh[i];
        end

        sel_v                = (state_q == e_locked) ? link.req_v_i[grant_q] : any_v;
        link.msg_v_o         = sel_v & ~reset_i;
        link.req_ready_and_o = reset_i ? '0 : (route_oh & {num_req_p{link.msg_ready_and_i}});
        grant_o              = reset_i ? '0 : route_idx;
        lock_o               = ~reset_i & (state_q == e_locked);

        xfer     = link.msg_v_o & link.msg_ready_and_i;
        msg_done = xfer & link.msg_last_o;
        // Explicit wrap compare keeps non-power-of-two counts in range.
        ptr_d    = (route_idx == lg_req_lp'(num_req_p - 1)) ? '0 : route_idx + lg_req_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                e_idle: begin
                    if (xfer) begin
                        if (link.msg_last_o) begin
                            ptr_q <= ptr_d;
                        end else begin
                            state_q <= e_locked;
                            grant_q <= sel;
                        end
                    end
                end
                e_locked: begin
                    if (msg_done) begin
                        state_q <= e_idle;
                        ptr_q   <= ptr_d;
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    a_hdr_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == e_locked && !msg_done) |=> $stable(link.msg_header_o));

    a_ptr_hold: assert property (@(posedge clk_i) disable iff (reset_i)
        (hold_on_valid_p != 0 && !msg_done) |=> $stable(ptr_q));

    for (genvar g = 0; g < num_req_p; g++) begin : g_v_hold
        a_v_hold: assert property (@(posedge clk_i) disable iff (reset_i)
            (link.req_v_i[g] && !link.req_ready_and_o[g]) |=> link.req_v_i[g]);
    end

endmodule

// File: tb/tb_bp_me_stream_arb_out.sv
// Scoreboard bench for bp_me_stream_arb_out with three requesters.
module tb_bp_me_stream_arb_out;
    import bp_me_stream_arb_out_pkg::*;

    localparam int N  = 3;
    localparam int H  = 128;
    localparam int D  = 64;
    localparam int LG = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [LG-1:0] grant;
    logic          lock;
    logic          toggle_rdy = 1'b0;

    bp_me_stream_arb_out_if #(.num_req_p(N), .header_width_p(H), .stream_data_width_p(D)) link();

    bp_me_stream_arb_out #(
        .num_req_p(N), .header_width_p(H), .stream_data_width_p(D), .hold_on_valid_p(0)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .link    (link),
        .grant_o (grant),
        .lock_o  (lock)
    );

    always #5 clk = ~clk;

    typedef struct { logic [H-1:0] hdr; logic [D-1:0] data; logic last; int gap; } beat_t;
    typedef struct { logic [H-1:0] hdr; logic [D-1:0] data; logic last; int src; } exp_t;

    beat_t src_q [N][$];
    exp_t  exp_q [$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    msg_id   = 0;

    // Expected beats are queued in the order the arbiter must emit them.
    task automatic send_msg(input int s, input int nb, input int gap_at, input int gap_len);
        beat_t        b;
        exp_t         e;
        logic [H-1:0] h;
        msg_id++;
        h = {64'(s), 64'(msg_id)};
        for (int k = 0; k < nb; k++) begin
            b.hdr  = h;
            b.data = {$urandom(), $urandom()};
            b.last = (k == nb - 1);
            b.gap  = (k == gap_at) ? gap_len : 0;
            src_q[s].push_back(b);
            e.hdr  = h;
            e.data = b.data;
            e.last = b.last;
            e.src  = s;
            exp_q.push_back(e);
        end
    endtask

    // Requester driver plus output monitor.
    initial begin : drv
        logic [N-1:0] hs;
        exp_t         e;
        beat_t        b;
        link.req_v_i         = '0;
        link.req_last_i      = '0;
        link.req_header_i    = '0;
        link.req_data_i      = '0;
        link.msg_ready_and_i = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            hs = link.req_v_i & link.req_ready_and_o;
            if (link.msg_v_o && link.msg_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got_hdr=%h required=none", link.msg_header_o);
                end else begin
                    e = exp_q.pop_front();
                    if (link.msg_header_o !== e.hdr) begin
                        failures++;
                        $display("FAIL beat_header got=%h required=%h", link.msg_header_o, e.hdr);
                    end
                    checks++;
                    if (link.msg_data_o !== e.data) begin
                        failures++;
                        $display("FAIL beat_data got=%h required=%h", link.msg_data_o, e.data);
                    end
                    checks++;
                    if (link.msg_last_o !== e.last) begin
                        failures++;
                        $display("FAIL beat_last got=%b required=%b", link.msg_last_o, e.last);
                    end
                    checks++;
                    if (grant !== LG'(e.src)) begin
                        failures++;
                        $display("FAIL beat_grant got=%0d required=%0d", grant, e.src);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    link.req_header_i[i*H +: H] = b.hdr;
                    link.req_data_i[i*D +: D]   = b.data;
                    link.req_last_i[i]          = b.last;
                    if (b.gap > 0) begin
                        b.gap--;
                        src_q[i][0] = b;
                        link.req_v_i[i] = 1'b0;
                    end else begin
                        link.req_v_i[i] = 1'b1;
                    end
                end else begin
                    link.req_v_i[i]    = 1'b0;
                    link.req_last_i[i] = 1'b0;
                end
            end
            link.msg_ready_and_i = toggle_rdy ? ~link.msg_ready_and_i : 1'b1;
        end
    end

    task automatic test_reset();
        int t = 0;
        repeat (2) @(posedge clk);
        #2;
        send_msg(0, 1, -1, 0);
        send_msg(2, 1, -1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (link.msg_v_o !== 1'b0) begin failures++; $display("FAIL rst_msg_v got=%b required=0", link.msg_v_o); end
        checks++;
        if (link.req_ready_and_o !== '0) begin failures++; $display("FAIL rst_ready got=%b required=000", link.req_ready_and_o); end
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL rst_lock got=%b required=0", lock); end
        checks++;
        if (grant !== '0) begin failures++; $display("FAIL rst_grant got=%0d required=0", grant); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        while (exp_q.size() > 0 && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rst_drain_timeout left=%0d required=0", exp_q.size()); end
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_multibeat();
        int t = 0, nx = 0, first = -1, lastc = -1;
        send_msg(1, 4, -1, 0);
        while (exp_q.size() > 0 && t < 50) begin
            @(negedge clk); #1; t++;
            if (link.msg_v_o && link.msg_ready_and_i) begin
                nx++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL mb_timeout left=%0d required=0", exp_q.size()); end
        checks++;
        if (nx != 4 || lastc - first + 1 != 4) begin
            failures++; $display("FAIL mb_consecutive got_n=%0d got_span=%0d required=4/4", nx, lastc - first + 1);
        end
        @(posedge clk);
        #2;
        // Pointer is now 2, so all-valid singles must come out 2,0,1.
        send_msg(2, 1, -1, 0);
        send_msg(0, 1, -1, 0);
        send_msg(1, 1, -1, 0);
        t = 0;
        while (exp_q.size() > 0 && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ptr_timeout left=%0d required=0", exp_q.size()); end
        @(posedge clk);
        #2;
    endtask

    task automatic test_two_req();
        int t = 0, nx = 0, first = -1, lastc = -1;
        send_msg(0, 2, -1, 0);
        send_msg(1, 2, -1, 0);
        while (exp_q.size() > 0 && t < 50) begin
            @(negedge clk); #1; t++;
            if (link.msg_v_o && grant == 0) begin
                checks++;
                if (link.req_ready_and_o[1] !== 1'b0) begin failures++; $display("FAIL two_ready1 got=1 required=0"); end
            end
            if (link.msg_v_o && link.msg_ready_and_i) begin
                nx++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL two_timeout left=%0d required=0", exp_q.size()); end
        checks++;
        if (nx != 4 || lastc - first + 1 != 4) begin
            failures++; $display("FAIL two_no_gap got_n=%0d got_span=%0d required=4/4", nx, lastc - first + 1);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_interleave();
        int t = 0, nx = 0, bubbles = 0;
        send_msg(0, 4, 1, 3);
        send_msg(1, 2, -1, 0);
        while (exp_q.size() > 0 && t < 50) begin
            @(negedge clk); #1; t++;
            if (lock && grant == 0) begin
                checks++;
                if (link.req_ready_and_o[1] !== 1'b0) begin failures++; $display("FAIL il_ready1 got=1 required=0"); end
                if (!link.msg_v_o) bubbles++;
            end
            if (link.msg_v_o && link.msg_ready_and_i) nx++;
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL il_timeout left=%0d required=0", exp_q.size()); end
        checks++;
        if (bubbles != 3 || nx != 6) begin
            failures++; $display("FAIL il_stall got_bubbles=%0d got_n=%0d required=3/6", bubbles, nx);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_backpressure();
        int t = 0, nx = 0, first = -1, lastc = -1;
        toggle_rdy = 1'b1;
        send_msg(2, 4, -1, 0);
        while (exp_q.size() > 0 && t < 50) begin
            @(negedge clk); #1; t++;
            if (nx >= 1 && nx < 4) begin
                checks++;
                if (lock !== 1'b1) begin failures++; $display("FAIL bp_lock got=%b required=1", lock); end
            end
            if (link.msg_v_o && link.msg_ready_and_i) begin
                nx++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        toggle_rdy = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_timeout left=%0d required=0", exp_q.size()); end
        checks++;
        if (nx != 4 || lastc - first + 1 != 7) begin
            failures++; $display("FAIL bp_count got_n=%0d got_span=%0d required=4/7", nx, lastc - first + 1);
        end
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
    endtask

    task automatic test_fairness();
        int t = 0, nx = 0, first = -1, lastc = -1;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++)
                send_msg(s, 1, -1, 0);
        while (exp_q.size() > 0 && t < 60) begin
            @(negedge clk); #1; t++;
            if (link.msg_v_o && link.msg_ready_and_i) begin
                nx++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL fair_timeout left=%0d required=0", exp_q.size()); end
        checks++;
        if (nx != 9 || lastc - first + 1 != 9) begin
            failures++; $display("FAIL fair_rate got_n=%0d got_span=%0d required=9/9", nx, lastc - first + 1);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_async_reset();
        int t = 0, nx = 0;
        send_msg(0, 1, -1, 0);
        send_msg(1, 4, -1, 0);
        while (nx < 3 && t < 50) begin
            @(negedge clk); #1; t++;
            if (link.msg_v_o && link.msg_ready_and_i) nx++;
        end
        checks++;
        if (nx != 3) begin failures++; $display("FAIL ar_pre_timeout got_n=%0d required=3", nx); end
        @(posedge clk);
        #3;
        checks++;
        if (lock !== 1'b1 || link.msg_v_o !== 1'b1 || grant !== LG'(1)) begin
            failures++; $display("FAIL ar_pre_state got_lock=%b got_v=%b got_grant=%0d required=1/1/1", lock, link.msg_v_o, grant);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (link.msg_v_o !== 1'b0) begin failures++; $display("FAIL ar_msg_v got=%b required=0", link.msg_v_o); end
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL ar_lock got=%b required=0", lock); end
        checks++;
        if (link.req_ready_and_o !== '0 || grant !== '0) begin
            failures++; $display("FAIL ar_ready_grant got_rdy=%b got_grant=%0d required=000/0", link.req_ready_and_o, grant);
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL ar_post_lock got=%b required=0", lock); end
        // Pointer was 1 before reset; order 0,1,2 shows it restarted at 0.
        send_msg(0, 1, -1, 0);
        send_msg(1, 1, -1, 0);
        send_msg(2, 1, -1, 0);
        t = 0;
        while (exp_q.size() > 0 && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ar_post_timeout left=%0d required=0", exp_q.size()); end
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_multibeat();
        test_two_req();
        test_interleave();
        test_backpressure();
        test_fairness();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog got=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
